syscall_print_unit: RTL and testbench



---
 rtl/syscall_print_unit_if.sv | 27 ++
 rtl/syscall_print_unit.sv | 209 ++++++++++++++++++++
 tb/tb_syscall_print_unit.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/syscall_print_unit_if.sv
// Console-syscall bundle between the core/memory/console side (master) and
// syscall_print_unit (slave). dbg_state mirrors the unit's FSM state for checkers.
interface syscall_print_unit_if;
  logic        syscall;
  logic [31:0] v0;
  logic [31:0] a0;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic [7:0]  char_data;
  logic        char_valid;
  logic        char_ready;
  logic        busy;
  logic        halted;
  logic [2:0]  dbg_state;

  // char stream: a character transfers on a rising clk edge where
  // char_valid & char_ready; char_data is held stable while char_valid=1.
  modport master (
    output syscall, v0, a0, mem_rdata, char_ready,
    input  mem_addr, char_data, char_valid, busy, halted, dbg_state
  );

  modport slave (
    input  syscall, v0, a0, mem_rdata, char_ready,
    output mem_addr, char_data, char_valid, busy, halted, dbg_state
  );
endinterface

// File: rtl/syscall_print_unit.sv
// Console syscall service unit: print char / string / int, and exit.
// Define SYSCALL_PRINT_INT_EN to build the signed-integer print service (v0=1).
module syscall_print_unit #(
  parameter int MAX_LEN = 256
) (
  input logic                  clk,
  input logic                  reset,
  syscall_print_unit_if.slave  bus
);
  localparam int CW = $clog2(MAX_LEN + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_CHECK    = 3'd2,
    S_EMIT     = 3'd3,
`ifdef SYSCALL_PRINT_INT_EN
    S_INT_DIG  = 3'd4,
    S_INT_EMIT = 3'd5,
`endif
    S_DONE     = 3'd6
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [31:0]     r_ptr;
  logic [CW-1:0]   r_count;
  logic [7:0]      r_char;
  logic            r_is_str;
  logic            r_halted;
  logic [7:0]      w_byte;
  logic            w_term;
  logic            w_take;
  logic            w_char_valid;
  logic            w_fire;

`ifdef SYSCALL_PRINT_INT_EN
  logic [31:0]     r_mag;
  logic            r_sign_pend;
  logic [3:0]      r_idx;
  logic [3:0]      r_digit;
  logic            r_started;
  logic [31:0]     w_pow;
  logic            w_sub_ok;
  logic            w_dig_out;

  always_comb begin
    w_pow = 32'd1;
    case (r_idx)
      4'd1: w_pow = 32'd10;
      4'd2: w_pow = 32'd100;
      4'd3: w_pow = 32'd1000;
      4'd4: w_pow = 32'd10000;
      4'd5: w_pow = 32'd100000;
      4'd6: w_pow = 32'd1000000;
      4'd7: w_pow = 32'd10000000;
      4'd8: w_pow = 32'd100000000;
      4'd9: w_pow = 32'd1000000000;
      default: w_pow = 32'd1;
    endcase
  end

  assign w_sub_ok  = (r_mag >= w_pow);
  // Digit is final once no more subtracts fit; print unless it is a leading zero.
  assign w_dig_out = !w_sub_ok && ((r_digit != 4'd0) || r_started || (r_idx == 4'd0));
`endif

  always_comb begin
    w_byte = 8'h00;
    case (r_ptr[1:0])
      2'd0: w_byte = bus.mem_rdata[31:24];
      2'd1: w_byte = bus.mem_rdata[23:16];
      2'd2: w_byte = bus.mem_rdata[15:8];
      2'd3: w_byte = bus.mem_rdata[7:0];
      default: w_byte = 8'h00;
    endcase
  end

  assign w_term = (w_byte == 8'h00) || (r_count == MAX_CNT);
  assign w_take = bus.syscall && !r_halted;

  always_comb begin
    w_char_valid = (r_state == S_EMIT);
`ifdef SYSCALL_PRINT_INT_EN
    w_char_valid = w_char_valid || (r_state == S_INT_EMIT);
`endif
  end

  assign w_fire = w_char_valid && bus.char_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_take) begin
          if (bus.v0 == 32'd11)     w_state_next = S_EMIT;
          else if (bus.v0 == 32'd4) w_state_next = S_FETCH;
`ifdef SYSCALL_PRINT_INT_EN
          else if (bus.v0 == 32'd1) w_state_next = S_INT_DIG;
`endif
        end
      end
      S_FETCH: w_state_next = S_CHECK;
      S_CHECK: w_state_next = w_term ? S_DONE : S_EMIT;
      S_EMIT:  if (w_fire) w_state_next = r_is_str ? S_FETCH : S_DONE;
`ifdef SYSCALL_PRINT_INT_EN
      S_INT_DIG: if (r_sign_pend || w_dig_out) w_state_next = S_INT_EMIT;
      S_INT_EMIT: begin
        if (w_fire) w_state_next = (r_sign_pend || (r_idx != 4'd0)) ? S_INT_DIG : S_DONE;
      end
`endif
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr    <= 32'd0;
      r_count  <= '0;
      r_char   <= 8'h00;
      r_is_str <= 1'b0;
      r_halted <= 1'b0;
`ifdef SYSCALL_PRINT_INT_EN
      r_mag       <= 32'd0;
      r_sign_pend <= 1'b0;
      r_idx       <= 4'd0;
      r_digit     <= 4'd0;
      r_started   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_take) begin
            case (bus.v0)
              32'd11: begin
                r_char   <= bus.a0[7:0];
                r_is_str <= 1'b0;
              end
              32'd4: begin
                r_ptr    <= bus.a0;
                r_count  <= '0;
                r_is_str <= 1'b1;
              end
              32'd10: r_halted <= 1'b1;
`ifdef SYSCALL_PRINT_INT_EN
              32'd1: begin
                r_mag       <= bus.a0[31] ? (~bus.a0 + 32'd1) : bus.a0;
                r_sign_pend <= bus.a0[31];
                r_idx       <= 4'd9;
                r_digit     <= 4'd0;
                r_started   <= 1'b0;
              end
`endif
              default: ;
            endcase
          end
        end
        S_CHECK: if (!w_term) r_char <= w_byte;
        S_EMIT: begin
          if (w_fire && r_is_str) begin
            r_ptr   <= r_ptr + 32'd1;
            r_count <= r_count + 1'b1;
          end
        end
`ifdef SYSCALL_PRINT_INT_EN
        S_INT_DIG: begin
          if (r_sign_pend) begin
            r_char <= 8'h2D;
          end else if (w_sub_ok) begin
            r_mag   <= r_mag - w_pow;
            r_digit <= r_digit + 4'd1;
          end else if (w_dig_out) begin
            r_char    <= 8'h30 + {4'h0, r_digit};
            r_started <= 1'b1;
          end else begin
            r_idx   <= r_idx - 4'd1;
            r_digit <= 4'd0;
          end
        end
        S_INT_EMIT: begin
          if (w_fire) begin
            if (r_sign_pend) begin
              r_sign_pend <= 1'b0;
            end else if (r_idx != 4'd0) begin
              r_idx   <= r_idx - 4'd1;
              r_digit <= 4'd0;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.mem_addr   = {r_ptr[31:2], 2'b00};
  assign bus.char_data  = r_char;
  assign bus.char_valid = w_char_valid;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.halted     = r_halted;
  assign bus.dbg_state  = r_state;
endmodule

// File: tb/tb_syscall_print_unit.sv
// Directed bench for syscall_print_unit: scoreboard queues for characters and
// fetch addresses, checked by a negedge monitor; directed timing checks inline.
module tb_syscall_print_unit;
  logic clk;
  logic reset;
  syscall_print_unit_if bus();

  syscall_print_unit #(.MAX_LEN(256)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // data memory: 256 words, read data registered one cycle after mem_addr
  logic [31:0] mem [0:255];
  always @(posedge clk) bus.mem_rdata <= mem[bus.mem_addr[9:2]];

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] addr_q[$];
  logic        held_v = 1'b0;
  logic [7:0]  held_d = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // monitor: pops on every char transfer and every FETCH cycle
  always @(negedge clk) begin
    if (!reset) begin
      if (held_v) begin
        n_tests++;
        if (!bus.char_valid || bus.char_data !== held_d) begin
          n_fail++;
          $display("FAIL char_hold: valid=%0b data=0x%0h, expected valid=1 data=0x%0h",
                   bus.char_valid, bus.char_data, held_d);
        end
      end
      if (bus.char_valid && bus.char_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL char_xfer: unexpected char 0x%0h, expected none", bus.char_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (bus.char_data !== e) begin
            n_fail++;
            $display("FAIL char_xfer: got 0x%0h, expected 0x%0h", bus.char_data, e);
          end
        end
        held_v = 1'b0;
      end else begin
        held_v = bus.char_valid;
        held_d = bus.char_data;
      end
      if (bus.dbg_state == 3'd1) begin
        n_tests++;
        if (addr_q.size() == 0) begin
          n_fail++;
          $display("FAIL fetch_addr: unexpected fetch at 0x%0h, expected none", bus.mem_addr);
        end else begin
          logic [31:0] ea;
          ea = addr_q.pop_front();
          if (bus.mem_addr !== ea) begin
            n_fail++;
            $display("FAIL fetch_addr: got 0x%0h, expected 0x%0h", bus.mem_addr, ea);
          end
        end
      end
    end else begin
      held_v = 1'b0;
    end
  end

  // driver tasks
  task automatic do_syscall(input logic [31:0] v, input logic [31:0] a);
    @(posedge clk); #1;
    bus.syscall = 1'b1;
    bus.v0      = v;
    bus.a0      = a;
    @(posedge clk); #1;
    bus.syscall = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k;
    k = 0;
    while (bus.busy && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    check(name, {31'd0, bus.busy}, 32'd0);
    @(posedge clk); #1;
    check({name, "_chars_left"}, exp_q.size(), 32'd0);
    check({name, "_fetch_left"}, addr_q.size(), 32'd0);
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  task automatic push_long(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(8'h41);
    for (int i = 0; i <= n; i++) addr_q.push_back((base + i) & 32'hFFFF_FFFC);
  endtask

  initial begin
    int k;
    for (int i = 0; i < 256; i++) mem[i] = 32'h4141_4141;
    mem[64] = 32'h4869_0000;
    bus.syscall    = 1'b0;
    bus.v0         = 32'd0;
    bus.a0         = 32'd0;
    bus.char_ready = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",       {31'd0, bus.busy},       32'd0);
    check("rst_halted",     {31'd0, bus.halted},     32'd0);
    check("rst_char_valid", {31'd0, bus.char_valid}, 32'd0);
    check("rst_char_data",  {24'd0, bus.char_data},  32'd0);
    check("rst_mem_addr",   bus.mem_addr,            32'd0);
    check("rst_state",      {29'd0, bus.dbg_state},  32'd0);
    reset = 1'b0;

    // print char: valid in N+1, busy for N+1..N+2
    exp_q.push_back(8'h41);
    do_syscall(32'd11, 32'h41);
    check("pc_valid_n1", {31'd0, bus.char_valid}, 32'd1);
    check("pc_data_n1",  {24'd0, bus.char_data},  32'h41);
    check("pc_busy_n1",  {31'd0, bus.busy},       32'd1);
    @(posedge clk); #1;
    check("pc_valid_n2", {31'd0, bus.char_valid}, 32'd0);
    check("pc_busy_n2",  {31'd0, bus.busy},       32'd1);
    @(posedge clk); #1;
    check("pc_busy_n3",  {31'd0, bus.busy},       32'd0);
    check("pc_chars_left", exp_q.size(), 32'd0);

    // "Hi" at 0x100
    push_str("Hi");
    repeat (3) addr_q.push_back(32'h100);
    do_syscall(32'd4, 32'h100);
    wait_idle(40, "str_hi");

    // 'A' at 0x103, 'B' at 0x104, with 5 cycles of backpressure on 'A'
    mem[64] = 32'h0000_0041;
    mem[65] = 32'h4200_0000;
    push_str("AB");
    addr_q.push_back(32'h100);
    addr_q.push_back(32'h104);
    addr_q.push_back(32'h104);
    bus.char_ready = 1'b0;
    do_syscall(32'd4, 32'h103);
    k = 0;
    while (!bus.char_valid && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {31'd0, bus.char_valid}, 32'd1);
      check("bp_data",  {24'd0, bus.char_data},  32'h41);
      @(posedge clk); #1;
    end
    bus.char_ready = 1'b1;
    wait_idle(40, "str_ab");

`ifdef SYSCALL_PRINT_INT_EN
    push_str("-305");
    do_syscall(32'd1, 32'hFFFF_FECF);
    wait_idle(300, "int_m305");
    push_str("0");
    do_syscall(32'd1, 32'd0);
    wait_idle(300, "int_zero");
    push_str("-2147483648");
    do_syscall(32'd1, 32'h8000_0000);
    wait_idle(300, "int_min");
`else
    do_syscall(32'd1, 32'd5);
    check("int_off_busy", {31'd0, bus.busy}, 32'd0);
    wait_idle(5, "int_off");
`endif

    // unknown service is ignored
    do_syscall(32'd7, 32'h41);
    check("unk_busy", {31'd0, bus.busy}, 32'd0);
    wait_idle(5, "unk");

    // unterminated string: forced stop after 256 characters
    push_long(32'h200, 256);
    do_syscall(32'd4, 32'h200);
    wait_idle(1200, "maxlen");

    // reset mid-string
    push_long(32'h200, 256);
    do_syscall(32'd4, 32'h200);
    repeat (20) @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    addr_q.delete();
    #1;
    check("mid_rst_char_valid", {31'd0, bus.char_valid}, 32'd0);
    check("mid_rst_busy",       {31'd0, bus.busy},       32'd0);
    check("mid_rst_char_data",  {24'd0, bus.char_data},  32'd0);
    check("mid_rst_mem_addr",   bus.mem_addr,            32'd0);
    check("mid_rst_state",      {29'd0, bus.dbg_state},  32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("post_rst_valid", {31'd0, bus.char_valid}, 32'd0);
    end

    // exit, then a print-char must be ignored
    do_syscall(32'd10, 32'd0);
    check("halt_set",  {31'd0, bus.halted}, 32'd1);
    check("halt_busy", {31'd0, bus.busy},   32'd0);
    do_syscall(32'd11, 32'h5A);
    check("halt_ign_busy",  {31'd0, bus.busy},       32'd0);
    check("halt_ign_valid", {31'd0, bus.char_valid}, 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check("halt_sticky", {31'd0, bus.halted}, 32'd1);
    check("final_chars_left", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
